// File: rtl/seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_scan_driver                                                            |
// | Multiplexed common-anode 7-segment scanner with blanking and frame-atomic   |
// | data updates.                                                              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seg_scan_driver #(
   parameter int DIGITS       = 4,
   parameter int BLANK_CYCLES = 4,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick_in,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   input  logic                  lz_en,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int              IW           = $clog2(DIGITS);
   localparam int              CW           = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [CW-1:0]   c_BLANK_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IW-1:0]   c_LAST_IDX   = IW'(DIGITS - 1);
   localparam logic            c_POL        = ACTIVE_LOW;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Tick synchronizer and rising-edge detect
   logic r_sync1, r_sync2, r_prev;
   logic w_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= tick_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_tick = r_sync2 & ~r_prev;

   state_t                r_state, w_state_nx;
   logic [IW-1:0]         r_idx, w_idx_nx, w_inc_idx;
   logic [CW-1:0]         r_cnt, w_cnt_nx;
   logic                  w_wrap, w_enter0, w_copy;

   logic [4*DIGITS-1:0]   r_pend_data, r_act_data, w_act_data_nx;
   logic [DIGITS-1:0]     r_pend_dp, r_act_dp, w_act_dp_nx;
   logic                  r_pend_lz, r_act_lz, w_act_lz_nx;
   logic                  r_pend_valid;

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_cnt_nx   = r_cnt;
      w_wrap     = 1'b0;
      w_inc_idx  = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (w_tick) begin
               w_state_nx = ST_SHOW;
               w_idx_nx   = '0;
            end
         end
         ST_SHOW: begin
            if (w_tick) begin
               if (BLANK_CYCLES > 0) begin
                  w_state_nx = ST_BLANK;
                  w_cnt_nx   = c_BLANK_LOAD;
               end else begin
                  w_idx_nx = w_inc_idx;
                  w_wrap   = (r_idx == c_LAST_IDX);
               end
            end
         end
         ST_BLANK: begin
            // Ticks landing here are intentionally dropped
            if (r_cnt == '0) begin
               w_state_nx = ST_SHOW;
               w_idx_nx   = w_inc_idx;
               w_wrap     = (r_idx == c_LAST_IDX);
            end else begin
               w_cnt_nx = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_idx_nx   = '0;
         end
      endcase
   end

   assign w_enter0      = ((r_state == ST_IDLE) && w_tick) || w_wrap;
   assign w_copy        = w_enter0 && r_pend_valid;
   assign w_act_data_nx = w_copy ? r_pend_data : r_act_data;
   assign w_act_dp_nx   = w_copy ? r_pend_dp   : r_act_dp;
   assign w_act_lz_nx   = w_copy ? r_pend_lz   : r_act_lz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // A load coinciding with the copy stays pending for the following frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_data  <= '0;
         r_pend_dp    <= '0;
         r_pend_lz    <= 1'b0;
         r_pend_valid <= 1'b0;
         r_act_data   <= '0;
         r_act_dp     <= '0;
         r_act_lz     <= 1'b0;
      end else begin
         if (load) begin
            r_pend_data  <= data_in;
            r_pend_dp    <= dp_in;
            r_pend_lz    <= lz_en;
            r_pend_valid <= 1'b1;
         end else if (w_copy) begin
            r_pend_valid <= 1'b0;
         end
         r_act_data <= w_act_data_nx;
         r_act_dp   <= w_act_dp_nx;
         r_act_lz   <= w_act_lz_nx;
      end
   end

   logic [DIGITS-1:0] w_lz_mask;
   logic              w_zero_run;
   logic [3:0]        w_nib;
   logic              w_dp_sel, w_sup;
   logic [6:0]        w_seg_l;
   logic [DIGITS-1:0] w_an_l;
   logic              w_dp_l;

   // Digit i is suppressed when it and every digit above it are zero
   always_comb begin
      w_lz_mask  = '0;
      w_zero_run = w_act_lz_nx;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_zero_run   = w_zero_run & (w_act_data_nx[4*i +: 4] == 4'h0);
         w_lz_mask[i] = w_zero_run;
      end
   end

   always_comb begin
      w_nib    = 4'h0;
      w_dp_sel = 1'b0;
      w_sup    = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_idx_nx == IW'(i)) begin
            w_nib    = w_act_data_nx[4*i +: 4];
            w_dp_sel = w_act_dp_nx[i];
            w_sup    = w_lz_mask[i];
         end
      end
   end

   always_comb begin
      w_seg_l = '0;
      w_an_l  = '0;
      w_dp_l  = 1'b0;
      if (w_state_nx == ST_SHOW) begin
         w_an_l  = DIGITS'(1) << w_idx_nx;
         w_seg_l = w_sup ? 7'h00 : hex7(w_nib);
         w_dp_l  = w_dp_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= {7{c_POL}};
         dp         <= c_POL;
         an         <= {DIGITS{c_POL}};
         frame_done <= 1'b0;
      end else begin
         seg        <= w_seg_l ^ {7{c_POL}};
         dp         <= w_dp_l ^ c_POL;
         an         <= w_an_l ^ {DIGITS{c_POL}};
         frame_done <= w_wrap;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg_scan_driver                                                         |
// | Scoreboard bench for seg_scan_driver (DIGITS=4, BLANK_CYCLES=4, active-low)|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick_in = 1'b0;
   logic [15:0] data_in = '0;
   logic [3:0]  dp_in = '0;
   logic        load = 1'b0;
   logic        lz_en = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   seg_scan_driver #(
      .DIGITS       (4),
      .BLANK_CYCLES (4),
      .ACTIVE_LOW   (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_in    (tick_in),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .load       (load),
      .lz_en      (lz_en),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
      logic [7:0] len;
   } exp_t;

   exp_t sb_q[$];

   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model of the display contents
   bit          m_run = 0;
   int          m_idx = 0;
   logic [15:0] m_act_d = '0, m_pend_d = '0;
   logic [3:0]  m_act_dp = '0, m_pend_dp = '0;
   logic        m_act_lz = 0, m_pend_lz = 0, m_pv = 0;

   task automatic push_off(input logic [7:0] len);
      exp_t e;
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0; e.len = len;
      sb_q.push_back(e);
   endtask

   task automatic push_show(input logic fd);
      exp_t e;
      logic [3:0] nib;
      int hi;
      logic sup;
      nib = m_act_d[4*m_idx +: 4];
      hi = 0;
      for (int i = 0; i < 4; i++)
         if (m_act_d[4*i +: 4] != 4'h0) hi = i;
      sup = m_act_lz && (m_idx > hi);
      e.an  = ~(4'b0001 << m_idx);
      e.seg = ~(sup ? 7'h00 : hex_tab[nib]);
      e.dp  = ~m_act_dp[m_idx];
      e.fd  = fd;
      e.len = 8'd0;
      sb_q.push_back(e);
   endtask

   task automatic model_copy();
      if (m_pv) begin
         m_act_d = m_pend_d; m_act_dp = m_pend_dp; m_act_lz = m_pend_lz; m_pv = 0;
      end
   endtask

   task automatic model_tick();
      if (!m_run) begin
         m_run = 1; m_idx = 0;
         model_copy();
         push_show(1'b0);
      end else begin
         push_off(8'd4);
         m_idx = (m_idx + 1) % 4;
         if (m_idx == 0) model_copy();
         push_show(m_idx == 0);
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic lz);
      @(negedge clk);
      data_in = d; dp_in = p; lz_en = lz; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      m_pend_d = d; m_pend_dp = p; m_pend_lz = lz; m_pv = 1;
   endtask

   task automatic do_tick(input bit lat);
      @(negedge clk);
      model_tick();
      tick_in = 1'b1;
      if (lat) begin
         @(posedge clk); @(posedge clk); #1;
         chk_eq("lat_edge2_an", an, 4'hF);
         @(posedge clk); #1;
         chk_eq("lat_edge3_an", an, 4'hE);
         @(posedge clk);
         @(negedge clk);
      end else begin
         repeat (4) @(negedge clk);
      end
      tick_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Second short pulse lands while the DUT is still blanking and must be ignored
   task automatic do_tick_blank();
      @(negedge clk);
      model_tick();
      tick_in = 1'b1;
      repeat (2) @(negedge clk);
      tick_in = 1'b0;
      repeat (2) @(negedge clk);
      tick_in = 1'b1;
      repeat (2) @(negedge clk);
      tick_in = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   // Output monitor: every change of the display pins consumes one scoreboard entry
   bit          mon_en = 0;
   logic [11:0] mon_prev;
   logic [7:0]  last_len = '0;
   int          run = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if ({an, seg, dp} !== mon_prev) begin
            exp_t e;
            if (last_len != 0) chk_eq("blank_len", run, 32'(last_len));
            if (sb_q.size() == 0) begin
               chk_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
               last_len = '0;
            end else begin
               e = sb_q.pop_front();
               chk_eq("ev_an", an, e.an);
               chk_eq("ev_seg", seg, e.seg);
               chk_eq("ev_dp", dp, e.dp);
               chk_eq("ev_frame_done", frame_done, e.fd);
               last_len = e.len;
            end
            mon_prev = {an, seg, dp};
            run = 1;
         end else begin
            run++;
            if (frame_done) chk_eq("fd_stray", frame_done, 1'b0);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk_eq("rst_an", an, 4'hF);
      chk_eq("rst_seg", seg, 7'h7F);
      chk_eq("rst_dp", dp, 1'b1);
      chk_eq("rst_frame_done", frame_done, 1'b0);
      @(posedge clk); #1;
      mon_prev = {an, seg, dp};
      mon_en = 1;

      do_load(16'h12AF, 4'b0100, 1'b0);
      do_tick(1'b1);
      repeat (4) do_tick(1'b0);

      do_load(16'h0050, 4'b0000, 1'b1);
      repeat (8) do_tick(1'b0);

      do_load(16'h0000, 4'b0000, 1'b1);
      repeat (8) do_tick(1'b0);

      do_load(16'h1234, 4'b0000, 1'b0);
      repeat (4) do_tick(1'b0);
      do_tick(1'b0);
      do_load(16'h9999, 4'b0000, 1'b0);
      do_tick_blank();
      do_tick(1'b0);
      do_tick(1'b0);

      do_tick(1'b0);
      do_tick(1'b0);
      push_off(8'd0);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("rst_mid_an", an, 4'hF);
      chk_eq("rst_mid_seg", seg, 7'h7F);
      chk_eq("rst_mid_fd", frame_done, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_run = 0; m_idx = 0;
      m_act_d = '0; m_act_dp = '0; m_act_lz = 0;
      m_pend_d = '0; m_pend_dp = '0; m_pend_lz = 0; m_pv = 0;
      repeat (3) @(negedge clk);
      repeat (5) do_tick(1'b0);

      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
      chk_eq("sb_drain", 32'(sb_q.size()), 32'd0);
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
